da_cmul_sequencer: RTL and testbench

Control sequencer for the two-LUT distributed-arithmetic (DA) complex vector multiplier engine.
- Accepts one 4-element complex input vector x (xr/xi) per transaction over a valid/ready handshake.
- Runs a real pass, then an imaginary pass, through the external LUT/accumulator datapath. Each pass is one bit-slice per cycle, LSB first.
- Forms yr = ar·xr − ai·xi and yi = ar·xi + ai·xr.
- Presents both results under a valid/ready output handshake.

---
 rtl/da_cmul_sequencer.sv | 179 +++++++++++++++++
 tb/tb_da_cmul_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/da_cmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : da_cmul_sequencer
// Brief    : Control sequencer for a two-LUT distributed-arithmetic complex
//            vector multiplier. It runs a real pass and then an imaginary pass,
//            one LSB-first bit-slice per cycle, and captures yr/yi.
//            Optional macro: DA_SCHED_BACK2BACK_EN lets DONE retire a result
//            and accept a new vector on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module da_cmul_sequencer #(
    parameter int XW = 8,
    parameter int AW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*XW-1:0] xr,
    input  logic [4*XW-1:0] xi,
    output logic [3:0]      slice1,
    output logic [3:0]      slice2,
    output logic            acc_en,
    output logic            acc_clr,
    output logic            acc_sub,
    input  logic [AW-1:0]   acc1_in,
    input  logic [AW-1:0]   acc2_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   yr,
    output logic [AW-1:0]   yi,
    output logic            busy
);

    localparam int              c_BW   = (XW > 1) ? $clog2(XW) : 1;
    localparam logic [c_BW-1:0] c_LAST = c_BW'(XW - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_RUN_RE = 3'd1;
    localparam logic [2:0] c_CAP_RE = 3'd2;
    localparam logic [2:0] c_RUN_IM = 3'd3;
    localparam logic [2:0] c_CAP_IM = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_BW-1:0] r_b;
    logic [c_BW-1:0] w_b_nxt;
    logic [4*XW-1:0] r_xr;
    logic [4*XW-1:0] r_xi;
    logic [AW-1:0]   r_yr;
    logic [AW-1:0]   r_yi;
    logic            w_accept;
    logic            w_run;
    logic [4*XW-1:0] w_src1;
    logic [4*XW-1:0] w_src2;
    logic [3:0]      w_bits1;
    logic [3:0]      w_bits2;

    // Ready is forced low while reset is held so nothing is accepted then.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
`ifdef DA_SCHED_BACK2BACK_EN
            in_ready = (r_state == c_IDLE) || ((r_state == c_DONE) && out_ready);
`else
            in_ready = (r_state == c_IDLE);
`endif
        end
    end

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_RUN_RE;
                    w_b_nxt     = '0;
                end
            end
            c_RUN_RE: begin
                w_b_nxt = r_b + c_BW'(1);
                if (r_b == c_LAST) begin
                    w_b_nxt     = '0;
                    w_state_nxt = c_CAP_RE;
                end
            end
            c_CAP_RE: w_state_nxt = c_RUN_IM;
            c_RUN_IM: begin
                w_b_nxt = r_b + c_BW'(1);
                if (r_b == c_LAST) begin
                    w_b_nxt     = '0;
                    w_state_nxt = c_CAP_IM;
                end
            end
            c_CAP_IM: w_state_nxt = c_DONE;
            c_DONE: begin
                // w_accept can only be set here when back-to-back is enabled.
                if (out_ready) begin
                    w_state_nxt = w_accept ? c_RUN_RE : c_IDLE;
                    w_b_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_b_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xr <= '0;
            r_xi <= '0;
            r_yr <= '0;
            r_yi <= '0;
        end else begin
            if (w_accept) begin
                r_xr <= xr;
                r_xi <= xi;
            end
            if (r_state == c_CAP_RE) begin
                r_yr <= acc1_in - acc2_in;
            end
            if (r_state == c_CAP_IM) begin
                r_yi <= acc1_in + acc2_in;
            end
        end
    end

    // The imaginary pass swaps which operand feeds each LUT.
    assign w_run  = (r_state == c_RUN_RE) || (r_state == c_RUN_IM);
    assign w_src1 = (r_state == c_RUN_IM) ? r_xi : r_xr;
    assign w_src2 = (r_state == c_RUN_IM) ? r_xr : r_xi;

    for (genvar g = 0; g < 4; g++) begin : g_slice
        logic [XW-1:0] w_e1;
        logic [XW-1:0] w_e2;
        assign w_e1       = w_src1[g*XW +: XW];
        assign w_e2       = w_src2[g*XW +: XW];
        assign w_bits1[g] = w_e1[r_b];
        assign w_bits2[g] = w_e2[r_b];
    end

    always_comb begin
        slice1  = 4'b0000;
        slice2  = 4'b0000;
        acc_en  = 1'b0;
        acc_clr = 1'b0;
        acc_sub = 1'b0;
        if (w_run) begin
            slice1  = w_bits1;
            slice2  = w_bits2;
            acc_en  = 1'b1;
            acc_clr = (r_b == '0);
            acc_sub = (r_b == c_LAST);
        end
    end

    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign yr        = r_yr;
    assign yi        = r_yi;

endmodule
`default_nettype wire

// File: tb/tb_da_cmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_da_cmul_sequencer
// Brief    : Self-checking bench for da_cmul_sequencer with a behavioural DA
//            datapath and an arithmetic reference for yr/yi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_da_cmul_sequencer;

    localparam int XW = 8;
    localparam int AW = 32;
`ifdef DA_SCHED_BACK2BACK_EN
    localparam int c_PERIOD = 2*XW + 3;
`else
    localparam int c_PERIOD = 2*XW + 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   xr;
    logic [31:0]   xi;
    logic [3:0]    slice1;
    logic [3:0]    slice2;
    logic          acc_en;
    logic          acc_clr;
    logic          acc_sub;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] yr;
    logic [AW-1:0] yi;
    logic          busy;

    int dp1, dp2, dpw, dpwe;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int ar [1:4];
    int ai [1:4];
    logic [3:0] rec_s1 [0:XW-1];

    logic [31:0] vr [0:2];
    logic [31:0] vi [0:2];
    logic [31:0] er6 [0:2];
    logic [31:0] ei6 [0:2];
    int nacc, nret, last;
    bit took;

    da_cmul_sequencer #(.XW(XW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .xr(xr), .xi(xi), .slice1(slice1), .slice2(slice2),
        .acc_en(acc_en), .acc_clr(acc_clr), .acc_sub(acc_sub),
        .acc1_in(dp1), .acc2_in(dp2), .out_valid(out_valid),
        .out_ready(out_ready), .yr(yr), .yi(yi), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LUT content: sum of the coefficients whose x-bit is set (bit3 = element 1).
    function automatic int lut(input bit use_ai, input logic [3:0] s);
        int v = 0;
        for (int k = 1; k <= 4; k++) if (s[4-k]) v += use_ai ? ai[k] : ar[k];
        return v;
    endfunction

    // Dot product of a coefficient set with a packed vector of signed bytes.
    function automatic int dot(input bit use_ai, input logic [31:0] x);
        int s = 0;
        for (int k = 1; k <= 4; k++) begin
            logic signed [7:0] e;
            e = x[(4-k)*XW +: XW];
            s += (use_ai ? ai[k] : ar[k]) * int'(e);
        end
        return s;
    endfunction

    function automatic logic [3:0] slc(input logic [31:0] x, input int i);
        logic [3:0] s;
        for (int k = 0; k < 4; k++) s[k] = x[k*XW + i];
        return s;
    endfunction

    // External DA datapath: weighted LSB-first accumulate, sign slice subtracted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp1 <= 0; dp2 <= 0; dpw <= 0;
        end else if (acc_en) begin
            dpwe = acc_clr ? 0 : dpw;
            dp1 <= (acc_clr ? 0 : dp1) + (acc_sub ? -(lut(0, slice1) << dpwe) : (lut(0, slice1) << dpwe));
            dp2 <= (acc_clr ? 0 : dp2) + (acc_sub ? -(lut(1, slice2) << dpwe) : (lut(1, slice2) << dpwe));
            dpw <= dpwe + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic [31:0] vxr, input logic [31:0] vxi, input int hold);
        logic [31:0] er, ei;
        logic [3:0]  es1, es2;
        int  lat, idx;
        bit  pre, pim, een;
        er = dot(0, vxr) - dot(1, vxi);
        ei = dot(0, vxi) + dot(1, vxr);
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("ready_before_txn", in_ready, 1);
        xr = vxr; xi = vxi; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; xr = $urandom; xi = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            pre = (lat < XW);
            pim = (lat >= XW + 1) && (lat < 2*XW + 1);
            een = pre || pim;
            idx = pre ? lat : (pim ? lat - XW - 1 : 0);
            es1 = pre ? slc(vxr, idx) : (pim ? slc(vxi, idx) : 4'b0);
            es2 = pre ? slc(vxi, idx) : (pim ? slc(vxr, idx) : 4'b0);
            if (pre) rec_s1[idx] = slice1;
            chk("decode", {acc_en, acc_clr, acc_sub, slice1, slice2, busy, in_ready},
                {een, een && idx == 0, een && idx == XW-1, es1, es2, 1'b1, 1'b0});
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, 2*XW + 2);
        chk("yr", yr, er);
        chk("yi", yi, ei);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1; xr = $urandom; xi = $urandom;
            chk("hold_flags", {out_valid, in_ready, busy}, 3'b101);
            chk("hold_y", {yr, yi}, {er, ei});
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        chk("valid_at_release", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 0;
        chk("after_retire", {out_valid, busy, in_ready}, 3'b001);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; xr = 0; xi = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_outputs", {in_ready, out_valid, busy, acc_en, acc_clr, acc_sub, slice1, slice2}, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_ready", {in_ready, busy, out_valid}, 3'b100);
        chk("post_rst_y", {yr, yi}, 64'd0);

        // Basic product
        ar[1] = 5; ar[2] = int'($urandom); ar[3] = int'($urandom); ar[4] = int'($urandom);
        ai[1] = 3; ai[2] = int'($urandom); ai[3] = int'($urandom); ai[4] = int'($urandom);
        do_txn(32'h0100_0000, 32'h0, 0);
        chk("basic_yr", yr, 32'd5);
        chk("basic_yi", yi, 32'd3);

        // Sign slice
        ai[1] = 0;
        do_txn(32'hFF00_0000, 32'h0, 0);
        chk("sign_yr", yr, 32'hFFFF_FFFB);
        chk("sign_yi", yi, 32'h0);

        // Slice ordering
        do_txn(32'h8100_0001, 32'h0, 0);
        chk("slice_b0", rec_s1[0], 4'b1001);
        chk("slice_b3", rec_s1[3], 4'b0000);
        chk("slice_b7", rec_s1[7], 4'b1000);

        // Backpressure with random operands
        for (int k = 1; k <= 4; k++) begin ar[k] = int'($urandom); ai[k] = int'($urandom); end
        do_txn($urandom, $urandom, 10);

        // Reset in the middle of the imaginary pass (b = 3)
        ar[1] = 5; ai[1] = 3;
        xr = 32'h0100_0000; xi = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (XW + 1 + 3) @(posedge clk);
        #1;
        chk("pre_rst_running", {acc_en, busy}, 2'b11);
        rst = 1;
        #1;
        chk("async_rst_outputs", {busy, out_valid, in_ready, acc_en, acc_clr, acc_sub, slice1, slice2}, 0);
        chk("async_rst_y", {yr, yi}, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("rst_release_ready", in_ready, 1);
        do_txn(32'h0100_0000, 32'h0, 0);
        chk("after_rst_yr", yr, 32'd5);
        chk("after_rst_yi", yi, 32'd3);

        // Random vectors
        for (int n = 0; n < 4; n++) begin
            for (int k = 1; k <= 4; k++) begin ar[k] = int'($urandom); ai[k] = int'($urandom); end
            do_txn($urandom, $urandom, int'($urandom_range(0, 3)));
        end

        // Streaming with in_valid and out_ready held high
        for (int n = 0; n < 3; n++) begin
            vr[n] = $urandom; vi[n] = $urandom;
            er6[n] = dot(0, vr[n]) - dot(1, vi[n]);
            ei6[n] = dot(0, vi[n]) + dot(1, vr[n]);
        end
        nacc = 0; nret = 0; last = 0;
        xr = vr[0]; xi = vi[0]; in_valid = 1; out_ready = 1;
        for (int t = 0; t < 300 && nret < 3; t++) begin
            took = in_valid && in_ready;
            if (out_valid) begin
                chk("stream_y", {yr, yi}, {er6[nret], ei6[nret]});
                if (nret > 0) chk("stream_period", cyc - last, c_PERIOD);
                last = cyc;
                nret++;
            end
            @(posedge clk); #1;
            if (took) begin
                nacc++;
                if (nacc < 3) begin xr = vr[nacc]; xi = vi[nacc]; end
                else in_valid = 0;
            end
        end
        chk("stream_count", nret, 3);
        in_valid = 0; out_ready = 0;
        repeat (3) @(posedge clk); #1;
        chk("stream_idle", {busy, in_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
